// File: rtl/rv32i_regfile.sv
// RV32I integer register file (x1..x31) with a load scoreboard: zero-cycle reads with writeback bypass.
// Writes and busy updates land on the clock edge; stall is combinational and tells issue to hold.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        rs1_used,
    input  logic        rs2_used,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    input  logic        busy_set,
    input  logic [4:0]  busy_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        stall,
    output logic [5:0]  pending_cnt
);

    logic [31:0] x_q [31:1];
    logic [31:0] x_d [31:1];
    logic [31:0] busy_q, busy_d;
    logic [5:0]  pending_cnt_q, pending_cnt_d;

    logic        wr_en, set_en, inc, dec;
    logic        rs1_byp, rs2_byp;
    logic [31:0] rs1_raw, rs2_raw;

    assign wr_en  = we && (rd_addr != 5'd0);
    assign set_en = busy_set && (busy_addr != 5'd0);

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            x_d[i] = x_q[i];
            if (wr_en && (rd_addr == 5'(i))) x_d[i] = rd_data;
        end

        // Set is applied after clear so a same-edge collision leaves the bit busy.
        busy_d = busy_q;
        if (wr_en)  busy_d[rd_addr]   = 1'b0;
        if (set_en) busy_d[busy_addr] = 1'b1;
        busy_d[0] = 1'b0;

        inc = set_en && !busy_q[busy_addr];
        dec = wr_en && busy_q[rd_addr] && !(set_en && (busy_addr == rd_addr));

        pending_cnt_d = pending_cnt_q;
        if (inc && !dec)      pending_cnt_d = pending_cnt_q + 6'd1;
        else if (dec && !inc) pending_cnt_d = pending_cnt_q - 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) x_q[i] <= 32'd0;
            busy_q        <= 32'd0;
            pending_cnt_q <= 6'd0;
        end else begin
            for (int i = 1; i < 32; i++) x_q[i] <= x_d[i];
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    // Index 0 never matches the loop, so x0 reads as zero without storage.
    always_comb begin
        rs1_raw = 32'd0;
        rs2_raw = 32'd0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_addr == 5'(i)) rs1_raw = x_q[i];
            if (rs2_addr == 5'(i)) rs2_raw = x_q[i];
        end
    end

    assign rs1_byp = wr_en && (rd_addr == rs1_addr);
    assign rs2_byp = wr_en && (rd_addr == rs2_addr);

    assign rs1_data = rs1_byp ? rd_data : rs1_raw;
    assign rs2_data = rs2_byp ? rd_data : rs2_raw;

    // A writeback landing this cycle resolves the hazard through the bypass.
    assign rs1_busy = busy_q[rs1_addr] && !rs1_byp;
    assign rs2_busy = busy_q[rs2_addr] && !rs2_byp;
    assign stall    = (rs1_busy && rs1_used) || (rs2_busy && rs2_used);

    assign pending_cnt = pending_cnt_q;

endmodule

// File: doc/rv32i_regfile.md
RV32I_REGFILE -- requirements
Module: rv32i_regfile

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, ports named clk and rst.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rs1_addr  in  5  source-1 register index.
- rs2_addr  in  5  source-2 register index.
- rs1_used  in  1  current instruction reads rs1.
- rs2_used  in  1  current instruction reads rs2.
- rs1_data  out  32  source-1 operand (ALU operand a).
- rs2_data  out  32  source-2 operand (ALU operand b path).
- we  in  1  writeback valid.
- rd_addr  in  5  writeback destination index.
- rd_data  in  32  writeback value (ALU result or load data).
- busy_set  in  1  issue of a long-latency write (load) to busy_addr.
- busy_addr  in  5  destination of the pending long-latency write.
- rs1_busy  out  1  rs1 has an outstanding write not yet available.
- rs2_busy  out  1  rs2 has an outstanding write not yet available.
- stall  out  1  operand hazard; the issue stage must hold.
- pending_cnt  out  6  number of set busy bits, 0..31.
REQ-003 SHALL have no parameters; widths are fixed at XLEN=32 and 32 architectural registers.

Function
REQ-004 Storage SHALL be x1..x31 as 32-bit flops; x0 SHALL NOT be stored and SHALL always read 0.
REQ-005 Reads SHALL be combinational from rs1_addr/rs2_addr with zero-cycle latency.
REQ-006 On a rising clk edge with we=1 and rd_addr!=0, x[rd_addr] SHALL take rd_data; we with rd_addr=0 SHALL have no effect.
REQ-007 Write-through bypass: if we=1, rd_addr!=0 and rd_addr==rsN_addr, rsN_data SHALL equal rd_data in the same cycle.
REQ-008 Reads of index 0 SHALL return 0 even when we=1 with rd_addr=0.
REQ-009 The scoreboard SHALL be 32 busy bits; busy[0] SHALL be constant 0.
REQ-010 On an edge with busy_set=1 and busy_addr!=0, busy[busy_addr] SHALL set to 1.
REQ-011 On an edge with we=1 and rd_addr!=0, busy[rd_addr] SHALL clear to 0.
REQ-012 If set and clear target the same index on the same edge, set SHALL win and the bit SHALL end at 1.
REQ-013 rsN_busy SHALL equal busy[rsN_addr] AND NOT (we AND rd_addr==rsN_addr AND rd_addr!=0), so a same-cycle writeback satisfies the hazard through the bypass.
REQ-014 stall SHALL equal (rs1_busy AND rs1_used) OR (rs2_busy AND rs2_used); it SHALL be combinational.
REQ-015 pending_cnt SHALL be a registered counter updated each edge:
- +1 when a bit transitions 0->1.
- -1 when a bit transitions 1->0.
- unchanged when both or neither occur.
- pending_cnt SHALL always equal the popcount of busy.
REQ-016 busy_set on an already-busy index SHALL NOT increment pending_cnt.
REQ-017 A write to a non-busy index SHALL NOT decrement pending_cnt.
REQ-018 busy_set SHALL be honoured regardless of stall.

Reset
REQ-019 While rst=1, asynchronously:
- x1..x31 SHALL be 0.
- all busy bits SHALL be 0.
- pending_cnt SHALL be 0.
- rs1_busy, rs2_busy and stall SHALL be 0.
REQ-020 A write or busy_set coincident with an edge while rst=1 SHALL be discarded.
REQ-021 Reset asserted mid-operation SHALL clear all outstanding pending writes.
REQ-022 After rst deasserts, the first edge SHALL perform normal updates.

Verification
REQ-023 Write x5=0xDEADBEEF, next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF; write x0=0x1234, rs2_addr=0 -> rs2_data=0.
REQ-024 Same cycle we=1, rd_addr=7, rd_data=0xA5A5A5A5, rs1_addr=rs2_addr=7 -> both outputs=0xA5A5A5A5 before the edge.
REQ-025 busy_set x3, then rs1_addr=3, rs1_used=1 -> stall=1, pending_cnt=1; then we=1, rd_addr=3 -> stall=0 that cycle, pending_cnt=0 next cycle.
REQ-026 Same edge busy_set x9 and we rd_addr=9 with x9 already busy -> busy[9]=1, pending_cnt unchanged; busy_set x0 -> pending_cnt unchanged.
REQ-027 Set x1..x31 busy -> pending_cnt=31; assert rst mid-cycle -> pending_cnt=0, stall=0, and all registers read 0 immediately.
REQ-028 rs2_busy=1 with rs2_used=0 -> stall=0.
